ex_operand_stage: RTL

- ID/EX pipeline register and operand-selection front end of the execute stage; drives the ALU's a, b, alu_ctrl and funct7b5 inputs directly.
- Captures decoded fields from ID each cycle. Resolves RAW hazards by forwarding from MEM and WB. Detects load-use hazards and requests a one-cycle ID stall. Inserts bubbles on stall or on a branch/jump flush.

---
 rtl/ex_operand_stage_if.sv | 69 ++++++
 rtl/ex_operand_stage.sv | 116 +++++++++++
 2 files changed

// File: rtl/ex_operand_stage_if.sv
// ID/EX operand-stage bus: decoded ID fields, MEM/WB writeback info and the
// registered execute-stage outputs that feed the ALU and memory stage.
interface ex_operand_stage_if #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
);
  logic             id_valid;
  logic [WIDTH-1:0] id_pc;
  logic [WIDTH-1:0] id_rs1_data;
  logic [WIDTH-1:0] id_rs2_data;
  logic [WIDTH-1:0] id_imm;
  logic [REGW-1:0]  id_rs1;
  logic [REGW-1:0]  id_rs2;
  logic [REGW-1:0]  id_rd;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [3:0]       id_alu_ctrl;
  logic             id_funct7b5;
  logic             id_alu_src_a;
  logic             id_alu_src_b;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             id_mem_write;
  logic             flush;

  logic [REGW-1:0]  mem_rd;
  logic             mem_reg_write;
  logic [WIDTH-1:0] mem_result;
  logic [REGW-1:0]  wb_rd;
  logic             wb_reg_write;
  logic [WIDTH-1:0] wb_result;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_ctrl;
  logic             alu_funct7b5;
  logic [WIDTH-1:0] ex_store_data;
  logic [WIDTH-1:0] ex_pc;
  logic [REGW-1:0]  ex_rd;
  logic             ex_valid;
  logic             ex_reg_write;
  logic             ex_mem_read;
  logic             ex_mem_write;
  logic             load_use_stall;

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
           id_alu_ctrl, id_funct7b5, id_alu_src_a, id_alu_src_b,
           id_reg_write, id_mem_read, id_mem_write, flush,
           mem_rd, mem_reg_write, mem_result,
           wb_rd, wb_reg_write, wb_result,
    input  alu_a, alu_b, alu_ctrl, alu_funct7b5, ex_store_data,
           ex_pc, ex_rd, ex_valid, ex_reg_write, ex_mem_read,
           ex_mem_write, load_use_stall
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
           id_alu_ctrl, id_funct7b5, id_alu_src_a, id_alu_src_b,
           id_reg_write, id_mem_read, id_mem_write, flush,
           mem_rd, mem_reg_write, mem_result,
           wb_rd, wb_reg_write, wb_result,
    output alu_a, alu_b, alu_ctrl, alu_funct7b5, ex_store_data,
           ex_pc, ex_rd, ex_valid, ex_reg_write, ex_mem_read,
           ex_mem_write, load_use_stall
  );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding, load-use stall
// detection and bubble insertion on stall or branch/jump flush.
module ex_operand_stage #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input logic                 clk,
  input logic                 rst_n,
  ex_operand_stage_if.slave   bus
);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] rs1_data;
    logic [WIDTH-1:0] rs2_data;
    logic [WIDTH-1:0] imm;
    logic [REGW-1:0]  rs1;
    logic [REGW-1:0]  rs2;
    logic [REGW-1:0]  rd;
    logic [3:0]       alu_ctrl;
    logic             funct7b5;
    logic             src_a;
    logic             src_b;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
  } ex_reg_t;

  ex_reg_t          ex_q;
  ex_reg_t          ex_d;
  logic             stall;
  logic [WIDTH-1:0] fwd_rs1;
  logic [WIDTH-1:0] fwd_rs2;

  // MEM is the younger producer, so it outranks WB; x0 is never forwarded.
  function automatic logic [WIDTH-1:0] forward(
    input logic [REGW-1:0]  rs,
    input logic [WIDTH-1:0] captured,
    input logic             mem_we,
    input logic [REGW-1:0]  mem_rd,
    input logic [WIDTH-1:0] mem_res,
    input logic             wb_we,
    input logic [REGW-1:0]  wb_rd,
    input logic [WIDTH-1:0] wb_res
  );
    if (mem_we && (mem_rd != '0) && (mem_rd == rs))
      return mem_res;
    else if (wb_we && (wb_rd != '0) && (wb_rd == rs))
      return wb_res;
    else
      return captured;
  endfunction

  // A flush squashes the ID instruction, so it also cancels any stall request.
  always_comb begin
    stall = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) &&
            bus.id_valid && !bus.flush &&
            ((bus.id_uses_rs1 && (bus.id_rs1 == ex_q.rd)) ||
             (bus.id_uses_rs2 && (bus.id_rs2 == ex_q.rd)));
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    ex_d = '0;
    if (!bus.flush && !stall && bus.id_valid) begin
      ex_d.valid     = 1'b1;
      ex_d.pc        = bus.id_pc;
      ex_d.rs1_data  = bus.id_rs1_data;
      ex_d.rs2_data  = bus.id_rs2_data;
      ex_d.imm       = bus.id_imm;
      ex_d.rs1       = bus.id_rs1;
      ex_d.rs2       = bus.id_rs2;
      ex_d.rd        = bus.id_rd;
      ex_d.alu_ctrl  = bus.id_alu_ctrl;
      ex_d.funct7b5  = bus.id_funct7b5;
      ex_d.src_a     = bus.id_alu_src_a;
      ex_d.src_b     = bus.id_alu_src_b;
      ex_d.reg_write = bus.id_reg_write;
      ex_d.mem_read  = bus.id_mem_read;
      ex_d.mem_write = bus.id_mem_write;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  always_comb begin
    fwd_rs1 = forward(ex_q.rs1, ex_q.rs1_data,
                      bus.mem_reg_write, bus.mem_rd, bus.mem_result,
                      bus.wb_reg_write, bus.wb_rd, bus.wb_result);
    fwd_rs2 = forward(ex_q.rs2, ex_q.rs2_data,
                      bus.mem_reg_write, bus.mem_rd, bus.mem_result,
                      bus.wb_reg_write, bus.wb_rd, bus.wb_result);
  end

  // Store data is always the forwarded rs2, even when the ALU takes the imm.
  assign bus.alu_a          = ex_q.src_a ? ex_q.pc  : fwd_rs1;
  assign bus.alu_b          = ex_q.src_b ? ex_q.imm : fwd_rs2;
  assign bus.ex_store_data  = fwd_rs2;
  assign bus.alu_ctrl       = ex_q.alu_ctrl;
  assign bus.alu_funct7b5   = ex_q.funct7b5;
  assign bus.ex_pc          = ex_q.pc;
  assign bus.ex_rd          = ex_q.rd;
  assign bus.ex_valid       = ex_q.valid;
  assign bus.ex_reg_write   = ex_q.reg_write;
  assign bus.ex_mem_read    = ex_q.mem_read;
  assign bus.ex_mem_write   = ex_q.mem_write;
  assign bus.load_use_stall = stall;

endmodule
